// File: rtl/xtal_osc_32k_ctrl.sv
// Start-up sequencer and clock monitor for the 32 kHz crystal oscillator.
// Powers the oscillator up with boost on. Boost stays on until enough dout
// edges have been seen, then the oscillator settles with boost off. After
// settling it reports ready and watches dout for loss of clock. Any failure
// latches a sticky fault, which only clr_fault removes.
// Every output is registered. The FSM state is visible on the state port.
module xtal_osc_32k_ctrl #(
  parameter int CNT_W         = 24,
  parameter int START_EDGES   = 16,
  parameter int SETTLE_EDGES  = 64,
  parameter int START_TIMEOUT = 2**22-1,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_fault,
  input  logic       osc_dout,
  output logic       osc_ena,
  output logic       osc_boost,
  output logic       ready,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'b000,
    S_BOOST  = 3'b001,
    S_SETTLE = 3'b010,
    S_RUN    = 3'b011,
    S_FAULT  = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_EDGES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EDGES - 1);
  localparam logic [CNT_W-1:0] START_TO    = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] LOSS_TO     = CNT_W'(LOSS_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           st;
  state_t           st_nxt;
  logic [1:0]       cause_nxt;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             dout_edge;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_inc;
  logic [CNT_W-1:0] edges;

  assign dout_edge = sync2 & ~prev;
  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + ONE;
  assign state     = st;

  // Bring dout into the clk domain and keep the previous sample for rise detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= osc_dout;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Next-state decision. en=0 has priority, then an edge, then a timeout.
  always_comb begin
    st_nxt    = st;
    cause_nxt = 2'b00;
    case (st)
      S_OFF: begin
        if (en) st_nxt = S_BOOST;
      end
      S_BOOST: begin
        // The BOOST timer counts total time in the state and edges do not clear it.
        // Only the terminal edge can pre-empt the start timeout.
        if (!en) begin
          st_nxt = S_OFF;
        end else if (dout_edge && edges == START_LAST) begin
          st_nxt = S_SETTLE;
        end else if (timer == START_TO) begin
          st_nxt    = S_FAULT;
          cause_nxt = 2'b01;
        end
      end
      S_SETTLE: begin
        if (!en) begin
          st_nxt = S_OFF;
        end else if (dout_edge) begin
          if (edges == SETTLE_LAST) st_nxt = S_RUN;
        end else if (timer == LOSS_TO) begin
          st_nxt    = S_FAULT;
          cause_nxt = 2'b10;
        end
      end
      S_RUN: begin
        if (!en) begin
          st_nxt = S_OFF;
        end else if (!dout_edge && timer == LOSS_TO) begin
          st_nxt    = S_FAULT;
          cause_nxt = 2'b11;
        end
      end
      S_FAULT: begin
        if (clr_fault) st_nxt = S_OFF;
      end
      default: st_nxt = S_OFF;
    endcase
  end

  // State register plus outputs decoded from the next state, so the pins change on the transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= S_OFF;
      osc_ena     <= 1'b0;
      osc_boost   <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      st        <= st_nxt;
      osc_ena   <= (st_nxt == S_BOOST) || (st_nxt == S_SETTLE) || (st_nxt == S_RUN);
      osc_boost <= (st_nxt == S_BOOST);
      ready     <= (st_nxt == S_RUN);
      fault     <= (st_nxt == S_FAULT);
      if (st_nxt != S_FAULT)
        fault_cause <= 2'b00;
      else if (st != S_FAULT)
        fault_cause <= cause_nxt;
    end
  end

  // Cycle timer and edge counter. Both clear on any state change. The timer saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
      edges <= '0;
    end else if (st_nxt != st) begin
      timer <= '0;
      edges <= '0;
    end else begin
      case (st)
        S_BOOST:        timer <= timer_inc;
        S_SETTLE, S_RUN: timer <= dout_edge ? '0 : timer_inc;
        default:        timer <= '0;
      endcase
      if ((st == S_BOOST || st == S_SETTLE) && dout_edge)
        edges <= edges + ONE;
    end
  end

endmodule
